// File: rtl/mul4su_share_arb.sv
// Round-robin front end that time-shares one external 4x4 signed-by-unsigned
// multiplier among N_REQ requesters and returns tagged products through a small FIFO.
module mul4su_share_arb #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [4*N_REQ-1:0]   req_s,
  input  logic [4*N_REQ-1:0]   req_u,
  output logic [3:0]           mul_s,
  output logic [3:0]           mul_u,
  input  logic [7:0]           mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_prod
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic signed [3:0] op_s_p1;
  logic [3:0]        op_u_p1;
  logic [ID_W-1:0]   op_id_p1;
  logic              vld_p1;

  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   cand;
  logic              grant_found;
  logic              can_accept;
  logic              accept;
  logic              pop;

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ID_W-1:0]   mem_id   [OUT_DEPTH];
  logic signed [7:0] mem_prod [OUT_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUT_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] i);
    if (i == LAST_ID) return '0;
    return i + 1'b1;
  endfunction

  assign rsp_valid  = (count != '0);
  assign pop        = rsp_valid & rsp_ready;
  // Space check counts the product already in flight in the operand register.
  assign can_accept = (int'(count) + int'(vld_p1) - int'(pop)) < OUT_DEPTH;

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = last;
    for (int k = 0; k < N_REQ; k++) begin
      cand = id_inc(cand);
      if (!grant_found && req_valid[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && grant_found && can_accept) req_ready[grant] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  // Stage 1: operand register feeding the external core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      op_s_p1  <= '0;
      op_u_p1  <= '0;
      op_id_p1 <= '0;
      last     <= LAST_ID;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        op_s_p1  <= $signed(req_s[{grant, 2'b00} +: 4]);
        op_u_p1  <= req_u[{grant, 2'b00} +: 4];
        op_id_p1 <= grant;
        last     <= grant;
      end
    end
  end

  assign mul_s = op_s_p1;
  assign mul_u = op_u_p1;

  // Stage 2: result FIFO write / head pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_id[i]   <= '0;
        mem_prod[i] <= '0;
      end
    end else begin
      if (vld_p1) begin
        mem_id[wr_ptr]   <= op_id_p1;
        mem_prod[wr_ptr] <= $signed(mul_p);
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({vld_p1, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rsp_id   = rsp_valid ? mem_id[rd_ptr] : '0;
  assign rsp_prod = rsp_valid ? mem_prod[rd_ptr] : '0;

endmodule

// File: tb/tb_mul4su_share_arb.sv
// Randomized bench for mul4su_share_arb against a queue-based reference of the
// arbitration, space accounting and ordered signed*unsigned results.
module tb_mul4su_share_arb;

  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [4*N-1:0]   req_s;
  logic [4*N-1:0]   req_u;
  logic [3:0]       mul_s;
  logic [3:0]       mul_u;
  logic [7:0]       mul_p;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [7:0]       rsp_prod;

  mul4su_share_arb #(.N_REQ(N), .ID_W(ID_W), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_u(req_u),
    .mul_s(mul_s), .mul_u(mul_u), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_prod(rsp_prod)
  );

  // Exact external core living at the parent level
  assign mul_p = 8'($signed({{4{mul_s[3]}}, mul_s}) * $signed({4'b0000, mul_u}));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [N-1:0] rv;
  logic [3:0]   rs [N];
  logic [3:0]   ru [N];
  logic         rr;

  int          mlast;
  bit          st_v;
  logic [3:0]  st_s, st_u;
  logic [1:0]  st_id;
  logic [7:0]  st_p;
  logic [1:0]  qid [$];
  logic [7:0]  qp  [$];
  bit          acc_v;
  int          acc_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_prod(input logic [3:0] s, input logic [3:0] u);
    int si;
    si = s[3] ? int'(s) - 16 : int'(s);
    return 8'(si * int'(u));
  endfunction

  task automatic model_reset();
    qid.delete();
    qp.delete();
    st_v  = 1'b0;
    mlast = N - 1;
    acc_v = 1'b0;
  endtask

  task automatic cycle();
    bit           exp_rv, pop, space, found, acc;
    int           g;
    logic [N-1:0] er;
    @(negedge clk);
    req_valid = rv;
    for (int i = 0; i < N; i++) begin
      req_s[4*i +: 4] = rs[i];
      req_u[4*i +: 4] = ru[i];
    end
    rsp_ready = rr;
    #1;
    exp_rv = (qid.size() > 0);
    pop    = exp_rv && rr;
    space  = (qid.size() + (st_v ? 1 : 0) - (pop ? 1 : 0)) < DEPTH;
    found  = 1'b0;
    g      = 0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (mlast + k) % N;
      if (!found && rv[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    acc = found && space;
    er  = '0;
    if (acc) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 32'(rsp_id), 32'(qid[0]));
      chk("rsp_prod", 32'(rsp_prod), 32'(qp[0]));
    end
    if (st_v) begin
      chk("mul_s", 32'(mul_s), 32'(st_s));
      chk("mul_u", 32'(mul_u), 32'(st_u));
    end
    @(posedge clk);
    if (pop) begin
      void'(qid.pop_front());
      void'(qp.pop_front());
    end
    if (st_v) begin
      qid.push_back(st_id);
      qp.push_back(st_p);
    end
    st_v = acc;
    if (acc) begin
      st_id = 2'(g);
      st_s  = rs[g];
      st_u  = ru[g];
      st_p  = ref_prod(rs[g], ru[g]);
      mlast = g;
    end
    acc_v = acc;
    acc_g = g;
  endtask

  initial begin
    bit   have [N];
    int   next, done;

    rst_n     = 1'b0;
    req_valid = '1;
    req_s     = '0;
    req_u     = '0;
    rsp_ready = 1'b1;
    rv        = '0;
    rr        = 1'b1;
    for (int i = 0; i < N; i++) begin
      rs[i] = '0;
      ru[i] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_prod", 32'(rsp_prod), 0);
    chk("rst_mul_s", 32'(mul_s), 0);
    chk("rst_mul_u", 32'(mul_u), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: -8 * 15
    rs[0] = 4'b1000; ru[0] = 4'd15; rv = 4'b0001;
    cycle();
    rv = '0;
    repeat (4) cycle();

    // Round-robin with everyone valid
    rs[0] = 4'(($urandom)); ru[0] = 4'(($urandom));
    rs[1] = 4'd7;           ru[1] = 4'd15;
    rs[2] = 4'hF;           ru[2] = 4'd1;
    rs[3] = 4'(($urandom)); ru[3] = 4'(($urandom));
    rv = 4'hF; rr = 1'b1;
    repeat (10) cycle();

    // Backpressure then drain
    rr = 1'b0;
    repeat (6) cycle();
    rr = 1'b1;
    repeat (6) cycle();
    rv = '0;
    repeat (4) cycle();

    // Exhaustive (s,u) sweep across random requesters with random rsp_ready
    for (int i = 0; i < N; i++) have[i] = 1'b0;
    next = 0;
    done = 0;
    for (int cyc = 0; cyc < 4000 && done < 256; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!have[i] && next < 256 && ($urandom % 2 == 0)) begin
          rs[i]   = next[7:4];
          ru[i]   = next[3:0];
          have[i] = 1'b1;
          next++;
        end
        rv[i] = have[i] && ($urandom % 4 != 0);
      end
      rr = ($urandom % 4 != 0);
      cycle();
      if (acc_v) begin
        have[acc_g] = 1'b0;
        done++;
      end
    end
    chk("sweep_done", 32'(done), 256);
    rv = '0; rr = 1'b1;
    repeat (4) cycle();

    // Reset with two results buffered
    for (int i = 0; i < N; i++) begin
      rs[i] = 4'($urandom);
      ru[i] = 4'($urandom);
    end
    rv = 4'hF; rr = 1'b0;
    repeat (4) cycle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_rsp_prod", 32'(rsp_prod), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rv = 4'b1100; rr = 1'b1;
    repeat (3) cycle();
    for (int c = 0; c < 20; c++) begin
      rv = 4'($urandom);
      rr = ($urandom % 2 == 0);
      cycle();
    end
    rv = '0; rr = 1'b1;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
